// File: rtl/audio_pkg.sv
// Shared audio definitions: I2S slot width, default sample width and the
// sample type exchanged between the voice generators and the serializer.
package audio_pkg;

    localparam int I2S_SLOT_BITS       = 16;
    localparam int DEFAULT_OUTPUT_BITS = 12;

    typedef logic signed [DEFAULT_OUTPUT_BITS-1:0] sample_t;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int clog2_min1(input int value);
        return ($clog2(value) < 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with first-word fall-through output; reset empties it
// by clearing the pointers and count, the storage itself is not cleared.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = DEFAULT_OUTPUT_BITS,
    parameter int DEPTH = 4
) (
    input  logic             main_clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on plain overflow.
    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge main_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/sample_serializer.sv
// Buffers signed mono samples and streams each one out as a stereo I2S frame
// (same sample in both slots), generating bclk and lrclk from main_clk.
module sample_serializer
    import audio_pkg::*;
#(
    parameter int OUTPUT_BITS = DEFAULT_OUTPUT_BITS,
    parameter int SLOT_BITS   = I2S_SLOT_BITS,
    parameter int BCLK_DIV    = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          main_clk,
    input  logic                          reset_n,
    input  logic signed [OUTPUT_BITS-1:0] sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          frame_start,
    output logic                          underrun
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = clog2_min1(BCLK_DIV);
    localparam int BIT_W      = clog2_min1(FRAME_BITS);
    localparam int PAD_BITS   = SLOT_BITS - OUTPUT_BITS;

    logic [DIV_W-1:0]       div_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [BIT_W-1:0]       bit_next;
    logic [BIT_W-1:0]       sdata_idx;
    logic [FRAME_BITS-1:0]  frame_word;
    logic [FRAME_BITS-1:0]  next_word;
    logic [SLOT_BITS-1:0]   slot_word;
    logic [OUTPUT_BITS-1:0] fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fe;
    logic                   frame_wrap;
    logic                   run_en;

    sample_fifo #(
        .WIDTH (OUTPUT_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .main_clk (main_clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .din      (sample_in),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // run_en keeps ready low through reset and for the reset cycle itself.
    assign sample_ready = run_en && !fifo_full;
    assign fifo_push    = sample_valid && sample_ready;

    assign fe         = bclk && (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign frame_wrap = fe && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign bit_next   = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);
    assign fifo_pop   = frame_wrap && !fifo_empty;
    assign slot_word  = SLOT_BITS'(fifo_dout) << PAD_BITS;
    assign next_word  = fifo_pop ? {slot_word, slot_word} : frame_word;

    // One-bit I2S delay: slot bit 0 of the old word is sent while the new one loads.
    always_comb begin
        sdata_idx = '0;
        if (bit_next != '0) begin
            sdata_idx = BIT_W'(FRAME_BITS - int'(bit_next));
        end
    end

    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_cnt == DIV_W'(BCLK_DIV - 1)) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            run_en      <= 1'b0;
            bit_cnt     <= '0;
            lrclk       <= 1'b0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            frame_word  <= '0;
        end else begin
            run_en      <= 1'b1;
            frame_start <= frame_wrap;
            if (frame_wrap && fifo_empty) begin
                underrun <= 1'b1;
            end
            if (fe) begin
                bit_cnt    <= bit_next;
                lrclk      <= (bit_next >= BIT_W'(SLOT_BITS));
                sdata      <= frame_word[sdata_idx];
                frame_word <= next_word;
            end
        end
    end

endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer: frames are reassembled from sdata and
// compared against hand-computed I2S words.
module tb_sample_serializer;
    import audio_pkg::*;

    typedef struct {
        sample_t     sample;
        logic [31:0] word;
    } vec_t;

    localparam logic [31:0] LR_PATTERN = 32'h0001_FFFE;

    logic    main_clk = 1'b0;
    logic    reset_n;
    sample_t sample_in;
    logic    sample_valid;
    logic    sample_ready;
    logic    bclk;
    logic    lrclk;
    logic    sdata;
    logic    frame_start;
    logic    underrun;

    int tests_run    = 0;
    int tests_failed = 0;

    vec_t    vecs [4];
    sample_t burst [5];
    vec_t    drain [5];

    sample_serializer dut (
        .main_clk     (main_clk),
        .reset_n      (reset_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 main_clk = ~main_clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input sample_t sample);
        sample_valid = valid;
        sample_in    = sample;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic waitFrameStart(input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < limit) begin
            tick();
            cycles++;
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL frame_start timeout: no pulse within %0d clks", limit);
        end
    endtask

    // Called on a frame_start cycle; returns on the following frame_start cycle.
    task automatic checkFrame(input string name, input logic [31:0] expected);
        logic [31:0] word;
        logic [31:0] lr;
        int          starts;
        word   = '0;
        lr     = '0;
        starts = 0;
        for (int k = 1; k <= 32; k++) begin
            for (int j = 0; j < 8; j++) begin
                tick();
                if (frame_start) starts++;
            end
            word[32-k] = sdata;
            lr[32-k]   = lrclk;
        end
        checkOutput({name, " word"}, word, expected);
        checkOutput({name, " lrclk"}, lr, LR_PATTERN);
        checkOutput({name, " start pulses"}, 32'(starts), 32'd1);
        checkOutput({name, " next start"}, {31'd0, frame_start}, 32'd1);
    endtask

    initial begin
        int  cycles;
        bit  ok;
        logic prev_ready;

        vecs[0] = '{sample: 12'h7FF, word: 32'h7FF0_7FF0};
        vecs[1] = '{sample: 12'h800, word: 32'h8000_8000};
        vecs[2] = '{sample: 12'h001, word: 32'h0010_0010};
        vecs[3] = '{sample: 12'h123, word: 32'h1230_1230};

        burst[0] = 12'h456;
        burst[1] = 12'hABC;
        burst[2] = 12'h3FF;
        burst[3] = 12'hC01;
        burst[4] = 12'h555;
        drain[0] = '{sample: 12'h456, word: 32'h4560_4560};
        drain[1] = '{sample: 12'hABC, word: 32'hABC0_ABC0};
        drain[2] = '{sample: 12'h3FF, word: 32'h3FF0_3FF0};
        drain[3] = '{sample: 12'hC01, word: 32'hC010_C010};
        drain[4] = '{sample: 12'hC01, word: 32'hC010_C010};

        reset_n      = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;

        // Reset state and divider start-up
        repeat (3) tick();
        checkOutput("reset bclk", {31'd0, bclk}, 32'd0);
        checkOutput("reset lrclk", {31'd0, lrclk}, 32'd0);
        checkOutput("reset sdata", {31'd0, sdata}, 32'd0);
        checkOutput("reset underrun", {31'd0, underrun}, 32'd0);
        checkOutput("reset frame_start", {31'd0, frame_start}, 32'd0);
        checkOutput("reset ready", {31'd0, sample_ready}, 32'd0);
        reset_n = 1'b1;
        tick();
        checkOutput("ready after release", {31'd0, sample_ready}, 32'd1);
        checkOutput("bclk clk1", {31'd0, bclk}, 32'd0);
        repeat (3) tick();
        checkOutput("bclk clk4", {31'd0, bclk}, 32'd1);
        repeat (3) tick();
        checkOutput("bclk clk7", {31'd0, bclk}, 32'd1);
        tick();
        checkOutput("bclk first fe", {31'd0, bclk}, 32'd0);
        checkOutput("lrclk first fe", {31'd0, lrclk}, 32'd0);

        // Fill the FIFO before the first frame start
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ready push %0d", i), {31'd0, sample_ready}, 32'd1);
            applyStimulus(1'b1, vecs[i].sample);
        end
        checkOutput("ready when full", {31'd0, sample_ready}, 32'd0);

        waitFrameStart(300, cycles, ok);
        checkOutput("first frame start clk", 32'(cycles + 12), 32'd256);
        checkOutput("underrun first frame", {31'd0, underrun}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            checkFrame($sformatf("frame %0d", i), vecs[i].word);
            checkOutput($sformatf("underrun after frame %0d", i), {31'd0, underrun},
                        (i == 3) ? 32'd1 : 32'd0);
        end

        // Empty FIFO: last sample repeats, underrun sticks
        checkFrame("repeat frame", 32'h1230_1230);
        checkOutput("underrun sticky", {31'd0, underrun}, 32'd1);

        // Five back-to-back pushes into an empty FIFO
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("burst ready %0d", i), {31'd0, sample_ready},
                        (i < 4) ? 32'd1 : 32'd0);
            applyStimulus(1'b1, burst[i]);
        end
        prev_ready = sample_ready;
        cycles     = 0;
        ok         = 1'b0;
        while (cycles < 300) begin
            tick();
            cycles++;
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
            prev_ready = sample_ready;
        end
        checkOutput("burst pop seen", {31'd0, ok}, 32'd1);
        checkOutput("ready before pop", {31'd0, prev_ready}, 32'd0);
        checkOutput("ready after pop", {31'd0, sample_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkFrame($sformatf("drain %0d", i), drain[i].word);
        end

        // Mid-frame reset at bit_cnt = 10
        applyStimulus(1'b1, 12'h0F0);
        repeat (83) tick();
        checkOutput("pre-reset bclk", {31'd0, bclk}, 32'd1);
        checkOutput("pre-reset underrun", {31'd0, underrun}, 32'd1);
        reset_n = 1'b0;
        tick();
        checkOutput("abort bclk", {31'd0, bclk}, 32'd0);
        checkOutput("abort lrclk", {31'd0, lrclk}, 32'd0);
        checkOutput("abort sdata", {31'd0, sdata}, 32'd0);
        checkOutput("abort underrun", {31'd0, underrun}, 32'd0);
        checkOutput("abort frame_start", {31'd0, frame_start}, 32'd0);
        checkOutput("abort ready", {31'd0, sample_ready}, 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        waitFrameStart(300, cycles, ok);
        checkOutput("post-reset frame clk", 32'(cycles), 32'd256);
        checkOutput("post-reset underrun", {31'd0, underrun}, 32'd1);
        checkFrame("post-reset frame", 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
